// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from vga_timing_gen to the GPU
//
// Signals:
//   pixel_ce        high on the clock in which x/y advance
//   x, y            raw pixel / line counters (10 bits)
//   h_sync, v_sync  active-low syncs
//   active          visible-area flag
//   blanking_start  one-clock strobe at the first pixel of vertical blanking
//   frame_cnt       frame counter (only when VGA_FRAME_CNT_EN is defined)
// Modports: master (timing generator drives), slave (GPU consumes).

interface vga_timing_gen_if;
    logic       pixel_ce;
    logic [9:0] x;
    logic [9:0] y;
    logic       h_sync;
    logic       v_sync;
    logic       active;
    logic       blanking_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    modport master (
        output pixel_ce, x, y, h_sync, v_sync, active, blanking_start
`ifdef VGA_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input pixel_ce, x, y, h_sync, v_sync, active, blanking_start
`ifdef VGA_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator on the system clock
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   vid    vga_timing_gen_if.master: pixel_ce, x, y, h_sync, v_sync, active,
//          blanking_start (and frame_cnt with VGA_FRAME_CNT_EN)
// Optional feature macro: VGA_FRAME_CNT_EN adds a 16-bit frame counter that
// steps on every blanking_start strobe.

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_timing_gen_if.master  vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // A one-bit prescaler still exists at CLK_DIV=1; it simply never leaves 0.
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0]    X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]    Y_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [PW-1:0] PS_LAST  = PW'(CLK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic          ce;
    logic          bstart;

    assign ce = (prescaler == PS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (ce) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (ce) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_q <= x_q + 10'd1;
            end
        end
    end

    // Qualified by ce so that with CLK_DIV>1 the pixel (0, V_ACTIVE), which
    // lasts CLK_DIV clocks, still yields a single-clock strobe.
    assign bstart = (x_q == 10'd0) && (y_q == Y_ACT) && ce;

    assign vid.pixel_ce       = ce;
    assign vid.x              = x_q;
    assign vid.y              = y_q;
    assign vid.active         = (x_q < X_ACT) && (y_q < Y_ACT);
    assign vid.h_sync         = !((x_q >= HS_START) && (x_q < HS_END));
    assign vid.v_sync         = !((y_q >= VS_START) && (y_q < VS_END));
    assign vid.blanking_start = bstart;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (bstart) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign vid.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen

module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    vga_timing_gen_if big_if ();
    vga_timing_gen_if s1_if ();
    vga_timing_gen_if s2_if ();

    // Full 640x480 timing, CLK_DIV=1.
    vga_timing_gen u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (big_if)
    );

    // Tiny raster 16x10 (8x6 visible), CLK_DIV=1: whole frames fit the budget.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1)
    ) u_s1 (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (s1_if)
    );

    // Same tiny raster, CLK_DIV=2.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2)
    ) u_s2 (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (s2_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held over two edges, released at a falling edge; returns at release.
    task automatic reset_all();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [24:0] got;
        rst_n = 1'b0;
        #3;
        @(posedge clk);
        #1;
        // {x, y, h_sync, v_sync, active, blanking_start, pixel_ce}
        got = {big_if.x, big_if.y, big_if.h_sync, big_if.v_sync, big_if.active,
               big_if.blanking_start, big_if.pixel_ce};
        checks++;
        if (got !== {10'd0, 10'd0, 5'b11101}) begin
            errors++;
            $display("FAIL reset_big got=%h exp=%h", got, {10'd0, 10'd0, 5'b11101});
        end
        got = {s1_if.x, s1_if.y, s1_if.h_sync, s1_if.v_sync, s1_if.active,
               s1_if.blanking_start, s1_if.pixel_ce};
        checks++;
        if (got !== {10'd0, 10'd0, 5'b11101}) begin
            errors++;
            $display("FAIL reset_s1 got=%h exp=%h", got, {10'd0, 10'd0, 5'b11101});
        end
        got = {s2_if.x, s2_if.y, s2_if.h_sync, s2_if.v_sync, s2_if.active,
               s2_if.blanking_start, s2_if.pixel_ce};
        checks++;
        if (got !== {10'd0, 10'd0, 5'b11100}) begin
            errors++;
            $display("FAIL reset_s2 got=%h exp=%h", got, {10'd0, 10'd0, 5'b11100});
        end
`ifdef VGA_FRAME_CNT_EN
        checks++;
        if (s1_if.frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt got=%0d exp=0", s1_if.frame_cnt);
        end
`endif
    endtask

    // Full-size line timing over three lines: x stepping, 799->0 wrap with
    // y increment, h_sync window 656..751 and active for x<640.
    task automatic test_horizontal();
        logic [24:0] got, exp;
        int ex, ey, hs_low;
        reset_all();
        #1;
        hs_low = 0;
        for (int n = 0; n < 2400; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            ex  = n % 800;
            ey  = n / 800;
            exp = {10'(ex), 10'(ey), !(ex >= 656 && ex <= 751), 1'b1,
                   (ex < 640), 1'b0, 1'b1};
            got = {big_if.x, big_if.y, big_if.h_sync, big_if.v_sync, big_if.active,
                   big_if.blanking_start, big_if.pixel_ce};
            if (n >= 800 && n < 1600 && big_if.h_sync === 1'b0) hs_low++;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL horiz n=%0d got=%h exp=%h", n, got, exp);
                break;
            end
        end
        checks++;
        if (hs_low != 96) begin
            errors++;
            $display("FAIL hsync_width got=%0d exp=96", hs_low);
        end
    endtask

    // Tiny raster, three frames: v_sync on lines 7..8, active x<8 && y<6,
    // blanking_start at (0,6), frame wrap (15,9) -> (0,0).
    task automatic test_vertical();
        logic [24:0] got, exp;
        int ex, ey, pulses, vs_low;
        reset_all();
        #1;
        pulses = 0;
        vs_low = 0;
        for (int n = 0; n < 480; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            ex  = n % 16;
            ey  = (n / 16) % 10;
            exp = {10'(ex), 10'(ey), !(ex >= 10 && ex <= 12), !(ey >= 7 && ey <= 8),
                   (ex < 8 && ey < 6), (ex == 0 && ey == 6), 1'b1};
            got = {s1_if.x, s1_if.y, s1_if.h_sync, s1_if.v_sync, s1_if.active,
                   s1_if.blanking_start, s1_if.pixel_ce};
            if (s1_if.blanking_start === 1'b1) pulses++;
            if (n < 160 && s1_if.v_sync === 1'b0) vs_low++;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL vert n=%0d got=%h exp=%h", n, got, exp);
                break;
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL bstart_count_div1 got=%0d exp=3", pulses);
        end
        checks++;
        if (vs_low != 32) begin
            errors++;
            $display("FAIL vsync_width got=%0d exp=32", vs_low);
        end
    endtask

    // CLK_DIV=2: pixel_ce alternates 0,1 from reset; each pixel lasts two
    // clocks; blanking_start only on the ce clock of pixel (0,6).
    task automatic test_div2();
        logic [24:0] got, exp;
        int p, ex, ey, ce, pulses;
        reset_all();
        #1;
        pulses = 0;
        for (int n = 0; n < 960; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            p   = n / 2;
            ce  = n % 2;
            ex  = p % 16;
            ey  = (p / 16) % 10;
            exp = {10'(ex), 10'(ey), !(ex >= 10 && ex <= 12), !(ey >= 7 && ey <= 8),
                   (ex < 8 && ey < 6), (ex == 0 && ey == 6 && ce == 1), ce[0]};
            got = {s2_if.x, s2_if.y, s2_if.h_sync, s2_if.v_sync, s2_if.active,
                   s2_if.blanking_start, s2_if.pixel_ce};
            if (s2_if.blanking_start === 1'b1) pulses++;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL div2 n=%0d got=%h exp=%h", n, got, exp);
                break;
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL bstart_count_div2 got=%0d exp=3", pulses);
        end
    endtask

    // Mid-frame asynchronous reset between clock edges, then restart from (0,0).
    task automatic test_async_reset();
        logic [24:0] got;
        reset_all();
        #1;
        repeat (123) @(posedge clk);
        #1;
        got = {s1_if.x, s1_if.y, s1_if.h_sync, s1_if.v_sync, s1_if.active,
               s1_if.blanking_start, s1_if.pixel_ce};
        checks++;
        if (got !== {10'd11, 10'd7, 5'b00001}) begin
            errors++;
            $display("FAIL pre_reset_s1 got=%h exp=%h", got, {10'd11, 10'd7, 5'b00001});
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {s1_if.x, s1_if.y, s1_if.h_sync, s1_if.v_sync, s1_if.active,
               s1_if.blanking_start, s1_if.pixel_ce};
        checks++;
        if (got !== {10'd0, 10'd0, 5'b11101}) begin
            errors++;
            $display("FAIL async_reset_s1 got=%h exp=%h", got, {10'd0, 10'd0, 5'b11101});
        end
        checks++;
        if (big_if.x !== 10'd0) begin
            errors++;
            $display("FAIL async_reset_big_x got=%0d exp=0", big_if.x);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({s1_if.x, s1_if.y} !== {10'd1, 10'd0}) begin
            errors++;
            $display("FAIL resume_s1 got=(%0d,%0d) exp=(1,0)", s1_if.x, s1_if.y);
        end
        checks++;
        if ({s2_if.x, s2_if.pixel_ce} !== {10'd0, 1'b1}) begin
            errors++;
            $display("FAIL resume_s2 got=x%0d ce%0b exp=x0 ce1", s2_if.x, s2_if.pixel_ce);
        end
    endtask

    task automatic test_frame_cnt();
`ifdef VGA_FRAME_CNT_EN
        reset_all();
        #1;
        checks++;
        if (s1_if.frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL frame_cnt_start got=%0d exp=0", s1_if.frame_cnt);
        end
        for (int n = 1; n <= 417; n++) begin
            @(posedge clk);
            #1;
            if (n == 96) begin
                checks++;
                if (s1_if.frame_cnt !== 16'd0) begin
                    errors++;
                    $display("FAIL frame_cnt_pre got=%0d exp=0", s1_if.frame_cnt);
                end
            end
            if (n == 97) begin
                checks++;
                if (s1_if.frame_cnt !== 16'd1) begin
                    errors++;
                    $display("FAIL frame_cnt_one got=%0d exp=1", s1_if.frame_cnt);
                end
            end
            if (n == 417) begin
                checks++;
                if (s1_if.frame_cnt !== 16'd3) begin
                    errors++;
                    $display("FAIL frame_cnt_three got=%0d exp=3", s1_if.frame_cnt);
                end
            end
        end
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        test_reset();
        test_horizontal();
        test_vertical();
        test_div2();
        test_async_reset();
        test_frame_cnt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
